// File: rtl/axi_burst_master_pkg.sv
// Shared types and constants for the AXI burst master: FSM state encoding,
// AXI burst/size/response codes and the 4 KB page boundary used for splitting.
package axi_burst_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AXI bursts may not cross this byte boundary.
  localparam int BOUNDARY_4K  = 4096;
  localparam int WORDS_PER_4K = BOUNDARY_4K / 4;

endpackage

// File: rtl/axi_burst_master_splitter.sv
// burst_splitter: combinational sub-burst sizing. The beat count is the
// smallest of the remaining beats, MAX_BEATS and the words left before the
// next 4 KB page; len is the AXI encoding (count - 1).
module burst_splitter
  import axi_burst_master_pkg::*;
#(
  parameter int MAX_BEATS = 256
) (
  input  logic [9:0]  cur_addr,    // word offset inside the current 4 KB page
  input  logic [9:0]  beats_left,
  output logic [10:0] count,
  output logic [7:0]  len
);

  localparam logic [10:0] MAX_B    = 11'(MAX_BEATS);
  localparam logic [10:0] WORDS_4K = 11'(WORDS_PER_4K);

  logic [10:0] room;
  logic [10:0] lim;

  // Clamp the remaining beats by the burst ceiling and by the page end.
  always_comb begin
    room  = WORDS_4K - {1'b0, cur_addr};
    lim   = (room < MAX_B) ? room : MAX_B;
    count = ({1'b0, beats_left} < lim) ? {1'b0, beats_left} : lim;
    len   = 8'(count - 11'd1);
  end

endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: turns a (byte address, byte length) request into one or
// more INCR AXI bursts of 32-bit beats, moving read data into a read FIFO or
// write data out of a first-word-fall-through write FIFO.
// Optional feature: define RESP_CHECK_EN to make bus_err track non-OKAY
// responses and rlast/beat-count disagreement; otherwise bus_err is 0.
module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int MAX_BEATS = 256,
  parameter int FIFO_DW   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  // requester
  input  logic                 rd_req,
  input  logic                 wr_req,
  input  logic [31:0]          addr,
  input  logic [11:0]          burst_length,
  output logic                 axi_done,
  output logic                 busy,
  output logic                 bus_err,
  // read FIFO
  output logic                 rfifo_wr_en,
  output logic [FIFO_DW-1:0]   rfifo_wdata,
  input  logic                 rfifo_full,
  // write FIFO
  output logic                 wfifo_rd_en,
  input  logic [FIFO_DW-1:0]   wfifo_rdata,
  input  logic                 wfifo_empty,
  // AR
  output logic [31:0]          m_axi_araddr,
  output logic [7:0]           m_axi_arlen,
  output logic [2:0]           m_axi_arsize,
  output logic [1:0]           m_axi_arburst,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  // R
  input  logic [FIFO_DW-1:0]   m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rlast,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready,
  // AW
  output logic [31:0]          m_axi_awaddr,
  output logic [7:0]           m_axi_awlen,
  output logic [2:0]           m_axi_awsize,
  output logic [1:0]           m_axi_awburst,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  // W
  output logic [FIFO_DW-1:0]   m_axi_wdata,
  output logic [FIFO_DW/8-1:0] m_axi_wstrb,
  output logic                 m_axi_wlast,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  // B
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready
);

  state_t      state, state_nxt;
  logic [29:0] cur_addr;      // word address of the next sub-burst
  logic [9:0]  beats_left;    // beats still to transfer in this transaction
  logic [10:0] beat_cnt;      // beats done inside the current sub-burst
  logic        arvalid_q;
  logic        awvalid_q;

  logic [10:0] sub_count;
  logic [7:0]  sub_len;
  logic [9:0]  beats_rem;
  logic [9:0]  req_beats;
  logic        last_beat;
  logic        accept;        // request taken in IDLE
  logic        sub_end;       // current sub-burst fully completed
  logic        beat_step;     // one data beat moved this cycle

  burst_splitter #(
    .MAX_BEATS (MAX_BEATS)
  ) u_splitter (
    .cur_addr   (cur_addr[9:0]),
    .beats_left (beats_left),
    .count      (sub_count),
    .len        (sub_len)
  );

  assign req_beats = burst_length[11:2];
  assign last_beat = (beat_cnt == sub_count - 11'd1);
  assign beats_rem = beats_left - sub_count[9:0];

  assign busy          = (state != ST_IDLE);
  assign m_axi_araddr  = {cur_addr, 2'b00};
  assign m_axi_arlen   = sub_len;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_awaddr  = {cur_addr, 2'b00};
  assign m_axi_awlen   = sub_len;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = wfifo_rdata;
  assign rfifo_wdata   = m_axi_rdata;

  // Next-state and channel handshake decode.
  always_comb begin
    state_nxt    = state;
    axi_done     = 1'b0;
    m_axi_rready = 1'b0;
    rfifo_wr_en  = 1'b0;
    m_axi_wvalid = 1'b0;
    m_axi_wlast  = 1'b0;
    wfifo_rd_en  = 1'b0;
    m_axi_bready = 1'b0;
    accept       = 1'b0;
    sub_end      = 1'b0;
    beat_step    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_req) begin
          accept    = 1'b1;
          state_nxt = (req_beats == 10'd0) ? ST_DONE : ST_AR;
        end else if (wr_req) begin
          accept    = 1'b1;
          state_nxt = (req_beats == 10'd0) ? ST_DONE : ST_AW;
        end
      end
      ST_AR: begin
        if (arvalid_q && m_axi_arready) state_nxt = ST_R;
      end
      ST_R: begin
        m_axi_rready = !rfifo_full;
        rfifo_wr_en  = m_axi_rvalid && !rfifo_full;
        if (rfifo_wr_en) begin
          beat_step = 1'b1;
          if (last_beat) begin
            sub_end   = 1'b1;
            state_nxt = (beats_rem != 10'd0) ? ST_AR : ST_DONE;
          end
        end
      end
      ST_AW: begin
        if (awvalid_q && m_axi_awready) state_nxt = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = !wfifo_empty;
        m_axi_wlast  = last_beat;
        wfifo_rd_en  = !wfifo_empty && m_axi_wready;
        if (wfifo_rd_en) begin
          beat_step = 1'b1;
          if (last_beat) state_nxt = ST_B;
        end
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          sub_end   = 1'b1;
          state_nxt = (beats_rem != 10'd0) ? ST_AW : ST_DONE;
        end
      end
      ST_DONE: begin
        axi_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Address/beat bookkeeping and registered address-channel valids.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr   <= '0;
      beats_left <= '0;
      beat_cnt   <= '0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
    end else begin
      arvalid_q <= (state_nxt == ST_AR);
      awvalid_q <= (state_nxt == ST_AW);
      if (accept) begin
        cur_addr   <= addr[31:2];
        beats_left <= req_beats;
      end else if (sub_end) begin
        cur_addr   <= cur_addr + {19'd0, sub_count};
        beats_left <= beats_rem;
      end
      if (accept || sub_end || (beat_step && last_beat)) beat_cnt <= '0;
      else if (beat_step)                                beat_cnt <= beat_cnt + 11'd1;
    end
  end

  // Sub-word address and length bits carry no meaning for word bursts.
  logic unused_lsbs;
  assign unused_lsbs = ^{addr[1:0], burst_length[1:0]};

`ifdef RESP_CHECK_EN
  logic bus_err_q;

  // Sticky error flag, cleared when the next request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err_q <= 1'b0;
    end else if (accept) begin
      bus_err_q <= 1'b0;
    end else if (rfifo_wr_en &&
                 ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat))) begin
      bus_err_q <= 1'b1;
    end else if ((state == ST_B) && m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY)) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{m_axi_rresp, m_axi_bresp, m_axi_rlast};
  assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: a randomised AXI slave and FIFO model drive the
// DUT; each transaction is compared against a burst plan computed from the
// 4 KB / MAX_BEATS splitting rules and against the expected data streams.
module tb_axi_burst_master;
  import axi_burst_master_pkg::*;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } burst_t;

  logic        clk, reset;
  logic        rd_req, wr_req;
  logic [31:0] addr;
  logic [11:0] burst_length;
  logic        axi_done, busy, bus_err;
  logic        rfifo_wr_en, rfifo_full;
  logic [31:0] rfifo_wdata;
  logic        wfifo_rd_en, wfifo_empty;
  logic [31:0] wfifo_rdata;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  axi_burst_master #(.MAX_BEATS(256), .FIFO_DW(32)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .burst_length(burst_length),
    .axi_done(axi_done), .busy(busy), .bus_err(bus_err),
    .rfifo_wr_en(rfifo_wr_en), .rfifo_wdata(rfifo_wdata), .rfifo_full(rfifo_full),
    .wfifo_rd_en(wfifo_rd_en), .wfifo_rdata(wfifo_rdata), .wfifo_empty(wfifo_empty),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // slave / FIFO model state and observation logs
  burst_t      ar_log[$], aw_log[$], rd_pend[$], exp_q[$];
  logic [31:0] rf_log[$], wdat_log[$], wq[$], wsrc[$];
  bit          wlast_log[$];
  int          r_beat, b_pend, cycle, done_cnt, done_cycle, last_rf_cycle;
  int          valid_seen, full_viol, rdy_pct;
  bit          full_toggle;
  logic [1:0]  bresp_cfg;
  logic        err_after_accept;

  function automatic logic [31:0] rhash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit chance();
    return ($urandom_range(99) < rdy_pct);
  endfunction

  // Burst plan straight from the rules: never exceed 256 beats or a 4 KB page.
  function automatic void build_model(input logic [31:0] a, input logic [11:0] bl);
    int words, room, cnt;
    logic [31:0] cur;
    burst_t b;
    exp_q.delete();
    words = int'(bl) / 4;
    cur   = {a[31:2], 2'b00};
    while (words > 0) begin
      room = (4096 - int'(cur % 4096)) / 4;
      cnt  = words;
      if (cnt > 256)  cnt = 256;
      if (cnt > room) cnt = room;
      b.addr = cur;
      b.len  = 8'(cnt - 1);
      exp_q.push_back(b);
      cur   = cur + 32'(cnt * 4);
      words = words - cnt;
    end
  endfunction

  // AXI slave and FIFO model: drive at edge+1, observe handshakes at edge+2.
  initial begin
    burst_t b;
    arready = 0; awready = 0; wready = 0; rvalid = 0; rdata = 0; rlast = 0;
    rresp = 2'b00; bvalid = 0; bresp = 2'b00; rfifo_full = 0;
    wfifo_empty = 1; wfifo_rdata = 0;
    r_beat = 0; b_pend = 0; cycle = 0; done_cnt = 0;
    forever begin
      @(posedge clk); #1;
      arready    = chance();
      awready    = chance();
      wready     = chance();
      rfifo_full = full_toggle ? ((cycle / 3) % 2 == 1) : 1'b0;
      if (rd_pend.size() > 0 && chance()) begin
        rvalid = 1'b1;
        rdata  = rhash(rd_pend[0].addr + 32'(r_beat * 4));
        rlast  = (r_beat == int'(rd_pend[0].len));
      end else begin
        rvalid = 1'b0;
        rdata  = $urandom;
        rlast  = 1'b0;
      end
      wfifo_empty = (wq.size() == 0) || !chance();
      wfifo_rdata = (wq.size() > 0) ? wq[0] : 32'hDEAD_BEEF;
      bvalid      = (b_pend > 0) && chance();
      bresp       = bresp_cfg;
      #1;
      cycle++;
      if (reset) begin
        rd_pend.delete();
        r_beat = 0;
        b_pend = 0;
      end else begin
        if (arvalid || awvalid) valid_seen++;
        if (rready && rfifo_full) full_viol++;
        if (arvalid && arready) begin
          b.addr = araddr; b.len = arlen;
          ar_log.push_back(b); rd_pend.push_back(b);
        end
        if (awvalid && awready) begin
          b.addr = awaddr; b.len = awlen;
          aw_log.push_back(b);
        end
        if (rvalid && rready && rd_pend.size() > 0) begin
          r_beat++;
          if (r_beat > int'(rd_pend[0].len)) begin
            void'(rd_pend.pop_front());
            r_beat = 0;
          end
        end
        if (rfifo_wr_en) begin
          rf_log.push_back(rfifo_wdata);
          last_rf_cycle = cycle;
        end
        if (wvalid && wready) begin
          wdat_log.push_back(wdata);
          wlast_log.push_back(wlast);
          if (wlast) b_pend++;
        end
        if (wfifo_rd_en && wq.size() > 0) void'(wq.pop_front());
        if (bvalid && bready) b_pend--;
        if (axi_done) begin
          done_cnt++;
          done_cycle = cycle;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // One full transaction checked against the plan and expected data.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [11:0] bl);
    int nw, d0, k;
    bit ok;
    logic [31:0] base, w;
    burst_t got[$];
    bit exp_last[$];
    build_model(a, bl);
    nw   = int'(bl[11:2]);
    base = {a[31:2], 2'b00};
    ar_log.delete(); aw_log.delete(); rf_log.delete();
    wdat_log.delete(); wlast_log.delete(); wsrc.delete(); wq.delete();
    valid_seen = 0; full_viol = 0;
    if (!rd && wr) for (int i = 0; i < nw; i++) begin
      w = $urandom; wsrc.push_back(w); wq.push_back(w);
    end
    d0 = done_cnt;
    cyc(); rd_req = rd; wr_req = wr; addr = a; burst_length = bl;
    cyc(); rd_req = 0; wr_req = 0;
    err_after_accept = bus_err;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_start got %b want 1", busy); end
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      cyc();
    end
    checks++; if (!ok) begin errors++; $display("FAIL done_timeout addr %h len %0d", a, bl); end
    cyc(); cyc();
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end got %b want 0", busy); end
    if (rd) begin
      got = ar_log;
      checks++; if (aw_log.size() != 0) begin errors++; $display("FAIL stray_aw got %0d want 0", aw_log.size()); end
    end else begin
      got = aw_log;
      checks++; if (ar_log.size() != 0) begin errors++; $display("FAIL stray_ar got %0d want 0", ar_log.size()); end
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL burst_count got %0d want %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL burst%0d got %h/%0d want %h/%0d", i, got[i].addr, got[i].len, exp_q[i].addr, exp_q[i].len);
        end
      end
    end
    if (rd) begin
      checks++;
      if (rf_log.size() != nw) begin
        errors++; $display("FAIL rfifo_count got %0d want %0d", rf_log.size(), nw);
      end else begin
        for (int i = 0; i < nw; i++) begin
          checks++;
          if (rf_log[i] !== rhash(base + 32'(i * 4))) begin
            errors++; $display("FAIL rword%0d got %h want %h", i, rf_log[i], rhash(base + 32'(i * 4)));
          end
        end
      end
    end else if (wr) begin
      foreach (exp_q[j]) for (k = 0; k <= int'(exp_q[j].len); k++) exp_last.push_back(k == int'(exp_q[j].len));
      checks++;
      if (wdat_log.size() != nw) begin
        errors++; $display("FAIL wbeat_count got %0d want %0d", wdat_log.size(), nw);
      end else begin
        for (int i = 0; i < nw; i++) begin
          checks++;
          if (wdat_log[i] !== wsrc[i] || wlast_log[i] !== exp_last[i]) begin
            errors++;
            $display("FAIL wbeat%0d got %h/%b want %h/%b", i, wdat_log[i], wlast_log[i], wsrc[i], exp_last[i]);
          end
        end
      end
      checks++; if (wq.size() != 0) begin errors++; $display("FAIL wfifo_left got %0d want 0", wq.size()); end
    end
    if (nw == 0) begin
      checks++; if (valid_seen != 0) begin errors++; $display("FAIL addr_valid_seen got %0d want 0", valid_seen); end
    end
    checks++; if (full_viol != 0) begin errors++; $display("FAIL rready_while_full got %0d want 0", full_viol); end
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    reset = 1; rd_req = 0; wr_req = 0; addr = 0; burst_length = 0;
    rdy_pct = 100; full_toggle = 0; bresp_cfg = AXI_RESP_OKAY;
    repeat (3) cyc();
    outs = {arvalid, awvalid, rready, rfifo_wr_en, wvalid, wlast, wfifo_rd_en, bready, axi_done, busy, bus_err};
    checks++; if (outs !== 11'd0) begin errors++; $display("FAIL reset_outputs got %b want 0", outs); end
    checks++; if ({arsize, awsize, arburst, awburst, wstrb} !== {AXI_SIZE_4B, AXI_SIZE_4B, AXI_BURST_INCR, AXI_BURST_INCR, 4'hF}) begin
      errors++; $display("FAIL const_fields got %b", {arsize, awsize, arburst, awburst, wstrb});
    end
    reset = 0;
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_read_basic();
    rdy_pct = 100; full_toggle = 0;
    run_txn(1, 0, 32'h0000_1000, 12'd1024);
    checks++; if (ar_log.size() != 1 || ar_log[0].len !== 8'd255) begin
      errors++; $display("FAIL read_1k_arlen got %0d bursts want one of len 255", ar_log.size());
    end
    checks++; if (done_cycle !== last_rf_cycle + 1) begin
      errors++; $display("FAIL done_latency got %0d want %0d", done_cycle, last_rf_cycle + 1);
    end
  endtask

  task automatic test_write_split();
    rdy_pct = 100; full_toggle = 0;
    run_txn(0, 1, 32'h0000_0FF0, 12'd64);
    checks++; if (aw_log.size() != 2 || aw_log[0] !== {32'h0000_0FF0, 8'd3} || aw_log[1] !== {32'h0000_1000, 8'd11}) begin
      errors++; $display("FAIL write_split got %0d bursts want 0FF0/3 and 1000/11", aw_log.size());
    end
    checks++; if (wlast_log.size() != 16 || !wlast_log[3] || !wlast_log[15]) begin
      errors++; $display("FAIL wlast_pos got %0d beats want wlast on 4 and 16", wlast_log.size());
    end
  endtask

  task automatic test_zero_len();
    rdy_pct = 100; full_toggle = 0;
    run_txn(1, 0, 32'h0000_0100, 12'd0);
    run_txn(0, 1, 32'h0000_0200, 12'd3);
    run_txn(1, 0, 32'h0000_0300, 12'd3);
  endtask

  task automatic test_fifo_full();
    rdy_pct = 100; full_toggle = 1;
    run_txn(1, 0, 32'h0000_5008, 12'd64);
    full_toggle = 0;
  endtask

  task automatic test_both_and_reset();
    bit ok;
    logic [10:0] outs;
    rdy_pct = 50; full_toggle = 0;
    ar_log.delete(); aw_log.delete(); rf_log.delete(); wq.delete();
    cyc(); rd_req = 1; wr_req = 1; addr = 32'h0000_2000; burst_length = 12'd256;
    cyc(); rd_req = 0; wr_req = 0;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (rf_log.size() >= 3) begin ok = 1; break; end
      cyc();
    end
    checks++; if (!ok) begin errors++; $display("FAIL both_req_timeout got %0d words", rf_log.size()); end
    checks++; if (aw_log.size() != 0 || ar_log.size() != 1 || ar_log[0].addr !== 32'h0000_2000) begin
      errors++; $display("FAIL read_priority got ar %0d aw %0d want ar 1 aw 0", ar_log.size(), aw_log.size());
    end
    cyc(); reset = 1; #1;
    outs = {arvalid, awvalid, rready, rfifo_wr_en, wvalid, wlast, wfifo_rd_en, bready, axi_done, busy, bus_err};
    checks++; if (outs !== 11'd0) begin errors++; $display("FAIL midR_reset_outputs got %b want 0", outs); end
    cyc(); cyc(); reset = 0;
    rdy_pct = 100;
    run_txn(1, 0, 32'h0000_3004, 12'd48);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 8; n++) begin
      rdy_pct     = $urandom_range(30, 100);
      full_toggle = $urandom_range(1);
      a = $urandom & 32'h0003_FFFF;
      if ($urandom_range(1)) a = (a & 32'hFFFF_F000) | (32'h0000_1000 - 32'($urandom_range(1, 64) * 4));
      run_txn($urandom_range(1), 1'b1, a, 12'($urandom_range(0, 1200)));
    end
    full_toggle = 0;
  endtask

  task automatic test_resp();
    logic exp_err;
`ifdef RESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rdy_pct = 100; bresp_cfg = AXI_RESP_SLVERR;
    run_txn(0, 1, 32'h0000_0040, 12'd32);
    checks++; if (bus_err !== exp_err) begin errors++; $display("FAIL bus_err_set got %b want %b", bus_err, exp_err); end
    bresp_cfg = AXI_RESP_OKAY;
    run_txn(1, 0, 32'h0000_0080, 12'd16);
    checks++; if (err_after_accept !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL bus_err_clear got %b/%b want 0/0", err_after_accept, bus_err);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_split();
    test_zero_len();
    test_fifo_full();
    test_both_and_reset();
    test_random();
    test_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 Parameters SHALL be, one per line:
- MAX_BEATS, 256, maximum beats per AXI sub-burst.
- FIFO_DW, 32, data width of the FIFO and AXI data.
REQ-002 Clock and reset SHALL be `clk` (in, 1, sole clock) and `reset` (in, 1), with one clock; reset is asynchronous and active-high.
REQ-003 The requester port SHALL be:
- `rd_req` in 1; `wr_req` in 1.
- `addr` in 32, byte address.
- `burst_length` in 12, bytes.
- `axi_done` out 1, completion pulse.
- `busy` out 1.
- `bus_err` out 1.
REQ-004 The read-FIFO port SHALL be:
- `rfifo_wr_en` out 1; `rfifo_wdata` out 32.
- `rfifo_full` in 1.
REQ-005 The write-FIFO port SHALL be:
- `wfifo_rd_en` out 1.
- `wfifo_rdata` in 32, first-word-fall-through.
- `wfifo_empty` in 1.
REQ-006 The AR channel SHALL be:
- `m_axi_araddr` out 32; `m_axi_arlen` out 8.
- `m_axi_arsize` out 3, const 3'b010; `m_axi_arburst` out 2, const INCR.
- `m_axi_arvalid` out 1; `m_axi_arready` in 1.
REQ-007 The R channel SHALL be: `m_axi_rdata` in 32; `m_axi_rresp` in 2; `m_axi_rlast` in 1; `m_axi_rvalid` in 1; `m_axi_rready` out 1.
REQ-008 The AW channel SHALL be: `m_axi_awaddr` out 32; `m_axi_awlen` out 8; `m_axi_awsize` out 3, const 3'b010; `m_axi_awburst` out 2, const INCR; `m_axi_awvalid` out 1; `m_axi_awready` in 1.
REQ-009 The W and B channels SHALL be: `m_axi_wdata` out 32; `m_axi_wstrb` out 4, const 4'hF; `m_axi_wlast` out 1; `m_axi_wvalid` out 1; `m_axi_wready` in 1; `m_axi_bresp` in 2; `m_axi_bvalid` in 1; `m_axi_bready` out 1.

Function
REQ-010 The FSM SHALL have the states IDLE, AR, R, AW, W, B and DONE, with `busy` = (state != IDLE).
REQ-011 In IDLE, a sampled `rd_req` SHALL latch addr[31:2], set beats_left = burst_length[11:2], and go to AR; `wr_req` SHALL do the same and go to AW; if both are high, read SHALL win.
REQ-012 If beats_left = 0 at request, the FSM SHALL go straight to DONE with no AXI traffic; burst_length[1:0] SHALL be ignored.
REQ-013 The sub-burst beat count SHALL be min(beats_left, MAX_BEATS, (4096 - cur_addr[11:0])/4), so that no burst crosses a 4 KB boundary; arlen/awlen SHALL be count-1.
REQ-014 `arvalid`/`awvalid` SHALL be registered, asserted the cycle after entering AR/AW, and held with stable address/len until ready; handshake SHALL go to R/W.
REQ-015 In R: `rready` = !rfifo_full; `rfifo_wr_en` = rvalid & rready; `rfifo_wdata` = rdata.
REQ-016 Sub-burst end in R SHALL be determined by the internal beat counter, not by rlast.
REQ-017 In W: `wvalid` = !wfifo_empty; `wdata` = wfifo_rdata; `wfifo_rd_en` = wvalid & wready; `wlast` SHALL be high on the final beat of the sub-burst.
REQ-018 After the last W beat the FSM SHALL go to B, with `bready` = 1 while in B.
REQ-019 On sub-burst end (last R beat, or B handshake), cur_addr SHALL advance by count*4 and beats_left SHALL decrease by count; the FSM SHALL return to AR/AW if beats_left > 0, else go to DONE.
REQ-020 DONE SHALL last exactly one cycle, with `axi_done` = 1, then go to IDLE; requests SHALL be ignored in DONE.
REQ-021 A request held high after `axi_done` SHALL start a new transaction from IDLE.

Reset
REQ-022 On `reset` assertion, state SHALL immediately become IDLE and all valid/ready/enable outputs, `axi_done`, `busy`, `bus_err` and counters SHALL be 0; in-flight AXI transfers SHALL be abandoned.

Configuration
REQ-023 With RESP_CHECK_EN defined, `bus_err` SHALL be sticky-set on rresp/bresp != OKAY, or on rlast mismatching the final-beat counter, and cleared at the next accepted request.
REQ-024 Without RESP_CHECK_EN, `bus_err` SHALL be tied to 0 and rresp, bresp and rlast SHALL be ignored.

Structure
REQ-025 A shared package SHALL hold the state enum, AXI burst/size/resp constants and the 4 KB boundary constant.
REQ-026 One sub-module, `burst_splitter` (combinational sub-burst count from cur_addr/beats_left), SHALL be used.

Verification
REQ-027 Read, addr=0x1000, burst_length=1024, always-ready slave -> one AR with arlen=255, 256 rfifo writes, `axi_done` pulse 1 cycle after the last R beat.
REQ-028 Write, addr=0x0FF0, burst_length=64 -> two AW bursts (awlen=3 @0x0FF0, awlen=11 @0x1000), 16 wfifo reads, `wlast` on beats 4 and 16.
REQ-029 burst_length=0 or 3 -> `axi_done` pulse with no arvalid/awvalid ever asserted.
REQ-030 Read with rfifo_full toggling every 3 cycles -> `rready` low while full; all 16 words written in order, none lost.
REQ-031 rd_req and wr_req together; then reset asserted mid-R -> read selected; after reset all outputs 0 and next request served normally.
REQ-032 RESP_CHECK_EN defined, bresp=SLVERR -> `bus_err`=1 after `axi_done`, cleared at next request.
